fetch_decode_stage: RTL and testbench
=====================================

// Module: fetch_decode_stage
// PURPOSE
//  Fetch front-end: PC counter, instruction-memory req/ack handshake, 1-entry skid buffer, IF/ID register.
//  Splits the latched instruction into MIPS fields.
//  id_imm16 drives the zero/sign extenders.
//  id_rs/id_rt/id_rd drive the register file.
// PARAMETERS
//  PC_RESET   32'h0000_0000  PC loaded on reset
//  PC_STEP    4              byte increment per sequential fetch
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   asynchronous, active-high
//  imem_req     out  1   fetch request; held high until imem_ack
//  imem_addr    out  32  fetch address; stable while imem_req && !imem_ack
//  imem_ack     in   1   one-cycle pulse; imem_rdata valid same cycle
//  imem_rdata   in   32  instruction word
//  stall        in   1   downstream hold; IF/ID contents frozen
//  redirect     in   1   one-cycle branch/jump taken pulse
//  redirect_pc  in   32  new PC; bits [1:0] forced to 0
//  id_valid     out  1   IF/ID holds a live instruction
//  id_pc        out  32  address of the IF/ID instruction
//  id_opcode    out  6   instr[31:26]
//  id_rs        out  5   instr[25:21]
//  id_rt        out  5   instr[20:16]
//  id_rd        out  5   instr[15:11]
//  id_shamt     out  5   instr[10:6]
//  id_funct     out  6   instr[5:0]
//  id_imm16     out  16  instr[15:0], to the extenders
// BEHAVIOUR
//  Reset values (async): pc=PC_RESET, state=BOOT, imem_req=0, id_valid=0, all id_* fields=0, skid empty.
//  States:
//   BOOT  -> FETCH on the first clk after reset deasserts.
//   FETCH -> imem_req=1, imem_addr=pc.
//   DRAIN -> request outstanding but result is to be discarded.
//  FETCH:
//   Ack, IF/ID free (!id_valid || !stall): load IF/ID, id_valid=1, pc+=PC_STEP.
//   Ack, IF/ID stalled: word goes to skid, pc+=PC_STEP.
//   No new request while skid full: imem_req=0 until the skid drains.
//  Stall release with skid full: skid moves to IF/ID next cycle, and imem_req reasserts the same cycle.
//  No instruction is lost or duplicated.
//  Stall with skid empty and no ack: IF/ID and pc hold; imem_req stays high.
//  Latency: ack at cycle N -> id_valid=1 at N+1 (skid empty, no stall).
//   Back-to-back acks sustain 1 instr/cycle.
//  Redirect (priority: reset > redirect > stall):
//   id_valid=0 and skid cleared next edge, regardless of stall.
//   Same cycle as ack, or no request outstanding: drop data, pc=redirect_pc, stay FETCH.
//   Request outstanding without ack: latch redirect_pc into pend_pc, go to DRAIN.
//    imem_req/addr stay unchanged.
//    On ack, drop data, pc=pend_pc, go to FETCH.
//   Second redirect in DRAIN overwrites pend_pc.
//  Arithmetic: pc+PC_STEP wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
//   redirect_pc[1:0] ignored (treated as 0).
//  When id_valid=0, id_* fields hold last values and are don't-care downstream.
//  Reset mid-request: imem_req drops asynchronously.
//   The memory must abandon the transaction.
//   A late ack in BOOT is ignored.
// STRUCTURE
//  Shared package mips_pkg:
//   field bit positions (OPC_HI/LO, RS_HI/LO, ...)
//   PC_STEP
//   fetch state encoding BOOT/FETCH/DRAIN
//   NOP word 32'h0000_0000
//  Sub-module fetch_skid_buffer: 1-entry {pc,instr} holding register.
//   Ports: push/pop/flush, full flag.
//  Top level holds PC, FSM and the IF/ID register.
// TESTING
//  1. Reset, then immediate acks at 0,4,8 with words 0x3C01_1234, 0x3421_00FF, 0x2002_FFFF.
//     -> id_valid at ack+1; id_imm16=0x1234, 0x00FF, 0xFFFF in order.
//     -> id_rt=1,1,2.
//  2. Stall during ack at addr 0x8, held 3 cycles.
//     -> word parked in skid; imem_req=0 while skid full.
//     -> on release, 0x8 appears, then fetch of 0xC; no gaps or duplicates.
//  3. Redirect to 0x0040_0003 while ack for 0x10 is pending 2 cycles later.
//     -> DRAIN; data at 0x10 discarded; next imem_addr=0x0040_0000.
//  4. Redirect same cycle as ack and stall=1.
//     -> id_valid=0 next cycle; skid empty; imem_addr=redirect target.
//  5. PC_RESET=32'hFFFF_FFFC, one ack.
//     -> id_pc=0xFFFF_FFFC, next imem_addr=0x0000_0000.
//  6. Assert reset mid-request (imem_req=1, no ack).
//     -> imem_req=0 and id_valid=0 immediately.
//     -> fetch restarts at PC_RESET one cycle after deassert.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: instruction field positions, fetch
// step, fetch FSM encoding and the skid-buffer entry type.
package mips_pkg;

   // Instruction field bit positions
   localparam int OPC_HI = 31;
   localparam int OPC_LO = 26;
   localparam int RS_HI  = 25;
   localparam int RS_LO  = 21;
   localparam int RT_HI  = 20;
   localparam int RT_LO  = 16;
   localparam int RD_HI  = 15;
   localparam int RD_LO  = 11;
   localparam int SH_HI  = 10;
   localparam int SH_LO  = 6;
   localparam int FN_HI  = 5;
   localparam int FN_LO  = 0;
   localparam int IMM_HI = 15;
   localparam int IMM_LO = 0;

   // Byte increment per sequential fetch
   localparam logic [31:0] PC_STEP = 32'd4;

   // All-zero word (sll r0,r0,0); also the IF/ID reset contents
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // Instruction addresses are word aligned; low bits are simply dropped
   function automatic logic [31:0] align_pc(input logic [31:0] a);
      return a & ~32'd3;
   endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {pc,instr} holding register that parks a fetched word while
// the IF/ID register is stalled.
module fetch_skid_buffer
   import mips_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t in_entry,
   output logic         full,
   output fetch_entry_t out_entry
);

   // Flush beats push beats pop; push and pop never coincide in use,
   // but a push while popping would correctly leave the new word held.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         full      <= 1'b0;
         out_entry <= '0;
      end else if (flush) begin
         full      <= 1'b0;
      end else if (push) begin
         full      <= 1'b1;
         out_entry <= in_entry;
      end else if (pop) begin
         full      <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_decode_stage.sv
// Fetch front-end: PC, imem req/ack handshake, skid buffer, IF/ID register
// and MIPS field split of the latched instruction.
module fetch_decode_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] PC_RESET = 32'h0000_0000
)(
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [5:0]  id_opcode,
   output logic [4:0]  id_rs,
   output logic [4:0]  id_rt,
   output logic [4:0]  id_rd,
   output logic [4:0]  id_shamt,
   output logic [5:0]  id_funct,
   output logic [15:0] id_imm16
);

   fetch_state_e state, state_nxt;
   logic [31:0]  pc, pc_nxt;
   logic [31:0]  pend_pc, pend_nxt;
   logic [31:0]  id_instr;
   logic [31:0]  tgt;
   logic         ack_fire;
   logic         keep_word;
   logic         if_free;
   logic         skid_full;
   logic         skid_push;
   logic         skid_pop;
   fetch_entry_t skid_in;
   fetch_entry_t skid_out;

   // Request is a pure function of registered state so that an async
   // reset drops it immediately; it is withheld while the skid is full.
   assign imem_req  = (state != BOOT) && !skid_full;
   assign imem_addr = pc;
   assign ack_fire  = imem_req && imem_ack;
   assign if_free   = !id_valid || !stall;
   assign tgt       = align_pc(redirect_pc);

   // A parked word always drains into IF/ID before a new fetch is issued
   assign skid_push = keep_word && !if_free && !redirect;
   assign skid_pop  = skid_full && if_free;
   assign skid_in   = '{pc: pc, instr: imem_rdata};

   fetch_skid_buffer u_skid (
      .clk       (clk),
      .reset     (reset),
      .push      (skid_push),
      .pop       (skid_pop),
      .flush     (redirect),
      .in_entry  (skid_in),
      .full      (skid_full),
      .out_entry (skid_out)
   );

   // FSM, PC and pending-redirect registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= BOOT;
         pc      <= PC_RESET;
         pend_pc <= PC_RESET;
      end else begin
         state   <= state_nxt;
         pc      <= pc_nxt;
         pend_pc <= pend_nxt;
      end
   end

   // Next-state: redirect steers the PC, or is deferred via DRAIN when a
   // request is already on the bus and must be allowed to complete.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      pend_nxt  = pend_pc;
      keep_word = 1'b0;
      case (state)
         BOOT: begin
            state_nxt = FETCH;
            if (redirect) pc_nxt = tgt;
         end
         FETCH: begin
            if (redirect) begin
               if (imem_req && !ack_fire) begin
                  pend_nxt  = tgt;
                  state_nxt = DRAIN;
               end else begin
                  pc_nxt = tgt;
               end
            end else if (ack_fire) begin
               pc_nxt    = pc + PC_STEP;
               keep_word = 1'b1;
            end
         end
         DRAIN: begin
            if (ack_fire) begin
               pc_nxt    = redirect ? tgt : pend_pc;
               state_nxt = FETCH;
            end else if (redirect) begin
               pend_nxt = tgt;
            end
         end
         default: state_nxt = BOOT;
      endcase
   end

   // IF/ID register: skid contents take precedence over a fresh word
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         id_valid <= 1'b0;
         id_pc    <= 32'h0;
         id_instr <= NOP_WORD;
      end else if (redirect) begin
         id_valid <= 1'b0;
      end else if (if_free) begin
         if (skid_full) begin
            id_valid <= 1'b1;
            id_pc    <= skid_out.pc;
            id_instr <= skid_out.instr;
         end else if (keep_word) begin
            id_valid <= 1'b1;
            id_pc    <= pc;
            id_instr <= imem_rdata;
         end else begin
            id_valid <= 1'b0;
         end
      end
   end

   assign id_opcode = id_instr[OPC_HI:OPC_LO];
   assign id_rs     = id_instr[RS_HI:RS_LO];
   assign id_rt     = id_instr[RT_HI:RT_LO];
   assign id_rd     = id_instr[RD_HI:RD_LO];
   assign id_shamt  = id_instr[SH_HI:SH_LO];
   assign id_funct  = id_instr[FN_HI:FN_LO];
   assign id_imm16  = id_instr[IMM_HI:IMM_LO];

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Bench for fetch_decode_stage: directed scenarios plus randomized
// ack/stall/redirect traffic checked against an in-order stream model.
module tb_fetch_decode_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req, imem_ack, stall, redirect, id_valid;
   logic [31:0] imem_addr, imem_rdata, redirect_pc, id_pc;
   logic [5:0]  id_opcode, id_funct;
   logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
   logic [15:0] id_imm16;

   // second instance with a PC_RESET at the top of the address space
   logic        h_req, h_ack, h_valid;
   logic [31:0] h_addr, h_rdata, h_pc;
   logic [5:0]  h_opcode, h_funct;
   logic [4:0]  h_rs, h_rt, h_rd, h_shamt;
   logic [15:0] h_imm16;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: words fetched but not yet consumed, in order
   logic [31:0] q_pc[$];
   logic [31:0] fetch_pc;
   logic [31:0] pend_pc;
   bit          stale;

   always #5 clk = ~clk;

   fetch_decode_stage #(.PC_RESET(32'h0000_0000)) u_dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
      .redirect(redirect), .redirect_pc(redirect_pc), .id_valid(id_valid),
      .id_pc(id_pc), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
      .id_rd(id_rd), .id_shamt(id_shamt), .id_funct(id_funct), .id_imm16(id_imm16)
   );

   fetch_decode_stage #(.PC_RESET(32'hFFFF_FFFC)) u_dut_hi (
      .clk(clk), .reset(reset), .imem_req(h_req), .imem_addr(h_addr),
      .imem_ack(h_ack), .imem_rdata(h_rdata), .stall(1'b0),
      .redirect(1'b0), .redirect_pc(32'h0), .id_valid(h_valid),
      .id_pc(h_pc), .id_opcode(h_opcode), .id_rs(h_rs), .id_rt(h_rt),
      .id_rd(h_rd), .id_shamt(h_shamt), .id_funct(h_funct), .id_imm16(h_imm16)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h3C01_1234;
         32'h4:   return 32'h3421_00FF;
         32'h8:   return 32'h2002_FFFF;
         default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
      endcase
   endfunction

   task automatic do_reset();
      reset = 1'b1; imem_ack = 1'b0; stall = 1'b0; redirect = 1'b0;
      redirect_pc = 32'h0; imem_rdata = 32'h0; h_ack = 1'b0; h_rdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req",    32'(imem_req), 32'd0);
      chk("rst_valid",  32'(id_valid), 32'd0);
      chk("rst_pc",     id_pc,         32'd0);
      chk("rst_opcode", 32'(id_opcode), 32'd0);
      chk("rst_rt",     32'(id_rt),    32'd0);
      chk("rst_imm16",  32'(id_imm16), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("boot_req", 32'(imem_req), 32'd0);
      q_pc.delete();
      fetch_pc = 32'h0;
      pend_pc  = 32'h0;
      stale    = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // One clock: check outputs against the model, drive this cycle's
   // inputs, advance the model, and return just after the rising edge.
   task automatic cycle(input bit want_ack, input bit st, input bit rd, input logic [31:0] tgt);
      logic        req_s, ack_s;
      logic [31:0] p, w, t;
      @(negedge clk);
      req_s = imem_req;
      chk("imem_req", 32'(imem_req), 32'(q_pc.size() < 2));
      chk("id_valid", 32'(id_valid), 32'(q_pc.size() != 0));
      if (req_s) chk("imem_addr", imem_addr, fetch_pc);
      if (q_pc.size() != 0 && !st && !rd) begin
         p = q_pc.pop_front();
         w = mem_word(p);
         chk("id_pc",     id_pc,           p);
         chk("id_opcode", 32'(id_opcode),  32'(w[31:26]));
         chk("id_rs",     32'(id_rs),      32'(w[25:21]));
         chk("id_rt",     32'(id_rt),      32'(w[20:16]));
         chk("id_rd",     32'(id_rd),      32'(w[15:11]));
         chk("id_shamt",  32'(id_shamt),   32'(w[10:6]));
         chk("id_funct",  32'(id_funct),   32'(w[5:0]));
         chk("id_imm16",  32'(id_imm16),   32'(w[15:0]));
      end
      ack_s       = want_ack && req_s;
      imem_ack    = ack_s;
      imem_rdata  = ack_s ? mem_word(imem_addr) : $urandom;
      stall       = st;
      redirect    = rd;
      redirect_pc = tgt;
      t = {tgt[31:2], 2'b00};
      if (rd) begin
         q_pc.delete();
         if (ack_s) begin
            fetch_pc = t; stale = 1'b0;
         end else if (req_s) begin
            stale = 1'b1; pend_pc = t;
         end else begin
            fetch_pc = t;
         end
      end else if (ack_s) begin
         if (stale) begin
            fetch_pc = pend_pc; stale = 1'b0;
         end else begin
            q_pc.push_back(fetch_pc);
            fetch_pc = fetch_pc + 32'd4;
         end
      end
      @(posedge clk);
      #1;
      imem_ack = 1'b0;
      redirect = 1'b0;
   endtask

   initial begin
      logic [31:0] rt;

      // 1: three immediate acks, one instruction per cycle
      do_reset();
      cycle(1, 0, 0, 0);
      chk("t1_valid0", 32'(id_valid), 32'd1);
      chk("t1_imm0",   32'(id_imm16), 32'h1234);
      chk("t1_rt0",    32'(id_rt),    32'd1);
      cycle(1, 0, 0, 0);
      chk("t1_imm1",   32'(id_imm16), 32'h00FF);
      chk("t1_rt1",    32'(id_rt),    32'd1);
      cycle(1, 0, 0, 0);
      chk("t1_imm2",   32'(id_imm16), 32'hFFFF);
      chk("t1_rt2",    32'(id_rt),    32'd2);

      // 2: ack for 0x8 while IF/ID is stalled, stall held 3 cycles
      do_reset();
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      cycle(1, 1, 0, 0);
      chk("t2_req_skid", 32'(imem_req), 32'd0);
      chk("t2_id_pc",    id_pc,         32'h4);
      cycle(0, 1, 0, 0);
      cycle(0, 1, 0, 0);
      chk("t2_req_hold", 32'(imem_req), 32'd0);
      cycle(0, 0, 0, 0);
      chk("t2_rel_pc",   id_pc,          32'h8);
      chk("t2_rel_req",  32'(imem_req),  32'd1);
      chk("t2_rel_addr", imem_addr,      32'hC);
      cycle(1, 0, 0, 0);
      chk("t2_next_pc",  id_pc,          32'hC);

      // 3: redirect while the fetch of 0x10 is outstanding
      cycle(0, 0, 1, 32'h0040_0003);
      chk("t3_drain_addr",  imem_addr,     32'h10);
      chk("t3_drain_valid", 32'(id_valid), 32'd0);
      cycle(0, 0, 0, 0);
      cycle(1, 0, 0, 0);
      chk("t3_drop_valid",  32'(id_valid), 32'd0);
      chk("t3_new_addr",    imem_addr,     32'h0040_0000);
      cycle(1, 0, 0, 0);
      chk("t3_new_pc",      id_pc,         32'h0040_0000);

      // 4: redirect together with ack and stall
      cycle(1, 1, 1, 32'h0000_2001);
      chk("t4_valid", 32'(id_valid), 32'd0);
      chk("t4_req",   32'(imem_req), 32'd1);
      chk("t4_addr",  imem_addr,     32'h2000);
      cycle(1, 0, 0, 0);
      chk("t4_pc",    id_pc,         32'h2000);

      // randomized traffic against the stream model
      for (int i = 0; i < 3000; i++) begin
         bit rd;
         logic [31:0] tg;
         rd = ($urandom_range(0, 15) == 0);
         tg = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
         cycle($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, rd, tg);
      end
      cycle(0, 0, 0, 0);

      // 5: PC wrap from the top of the address space
      do_reset();
      @(negedge clk);
      chk("t5_req",  32'(h_req), 32'd1);
      chk("t5_addr", h_addr,     32'hFFFF_FFFC);
      h_ack   = 1'b1;
      h_rdata = 32'h2402_0007;
      @(posedge clk);
      #1;
      h_ack = 1'b0;
      chk("t5_valid", 32'(h_valid), 32'd1);
      chk("t5_pc",    h_pc,         32'hFFFF_FFFC);
      chk("t5_imm",   32'(h_imm16), 32'h0007);
      chk("t5_wrap",  h_addr,       32'h0);

      // 6: reset mid-request, late ack during BOOT ignored
      do_reset();
      cycle(1, 0, 0, 0);
      cycle(0, 1, 0, 0);
      chk("t6_pre_valid", 32'(id_valid), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_req_async",   32'(imem_req), 32'd0);
      chk("t6_valid_async", 32'(id_valid), 32'd0);
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("t6_boot_req", 32'(imem_req), 32'd0);
      q_pc.delete();
      fetch_pc = 32'h0;
      stale    = 1'b0;
      @(posedge clk);
      #1;
      imem_ack = 1'b0;
      cycle(1, 0, 0, 0);
      chk("t6_restart_pc", id_pc, 32'h0);
      rt = 32'(id_imm16);
      chk("t6_restart_imm", rt, 32'h1234);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
